// File: rtl/checkbit_mon_pkg.sv
// Shared types and constants for the checkbit round monitor.
// State encoding, failure codes and default marker values.
package checkbit_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FAIL
  } state_t;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
  localparam logic [1:0] FAIL_RESTART = 2'b10;

  localparam logic [15:0] DEF_START_CODE = 16'h00A5;
  localparam logic [15:0] DEF_PASS_CODE  = 16'h765A;

endpackage

// File: rtl/checkbit_sync_filter.sv
// Synchronizer, stability filter and marker edge detect
// for the asynchronous checkbit word.
module checkbit_sync_filter
  import checkbit_mon_pkg::*;
#(
  parameter logic [15:0] START_CODE = DEF_START_CODE,
  parameter logic [15:0] PASS_CODE  = DEF_PASS_CODE,
  parameter int          STABLE_CYC = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        clear,
  input  logic [15:0] checkbits,
  output logic [15:0] code,
  output logic        start_ev,
  output logic        pass_ev
);

  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [15:0] cand;
  logic [3:0]  stab_cnt;
  logic [3:0]  stab_nx;
  logic [15:0] code_nx;

  // Count consecutive equal samples; qualify once the run is long enough
  always_comb begin
    stab_nx = 4'd1;
    if (sync2 == cand) begin
      stab_nx = (stab_cnt == 4'hF) ? stab_cnt : stab_cnt + 4'd1;
    end
    code_nx = code;
    if (stab_nx >= 4'(STABLE_CYC)) begin
      code_nx = sync2;
    end
  end

  // Sync chain, filter state and single-cycle marker events
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      stab_cnt <= '0;
      code     <= '0;
      start_ev <= 1'b0;
      pass_ev  <= 1'b0;
    end else if (clear) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      stab_cnt <= '0;
      code     <= '0;
      start_ev <= 1'b0;
      pass_ev  <= 1'b0;
    end else begin
      sync1    <= checkbits;
      sync2    <= sync1;
      cand     <= sync2;
      stab_cnt <= stab_nx;
      code     <= code_nx;
      start_ev <= (code_nx != code) && (code_nx == START_CODE);
      pass_ev  <= (code_nx != code) && (code_nx == PASS_CODE);
    end
  end

endmodule

// File: rtl/checkbit_round_monitor.sv
// Round monitor: times START->PASS rounds on the checkbit word
// and reports overall pass, timeout or restart errors.
module checkbit_round_monitor
  import checkbit_mon_pkg::*;
#(
  parameter logic [15:0] START_CODE     = DEF_START_CODE,
  parameter logic [15:0] PASS_CODE      = DEF_PASS_CODE,
  parameter int          NUM_ROUNDS     = 3,
  parameter int          CNT_W          = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
  parameter int          STABLE_CYC     = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [15:0]      checkbits,
  input  logic             clear,
  output logic             round_active,
  output logic [3:0]       round_idx,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_cycles,
  output logic             pass_all,
  output logic             fail,
  output logic [1:0]       fail_code
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      qual_code;
  logic             start_ev;
  logic             pass_ev;
  logic             start_hit;
  logic             pass_hit;
  logic [CNT_W:0]   cnt_p1;
  logic [CNT_W-1:0] cnt_sat;
  logic             timeout_hit;
  logic [3:0]       round_nx;

  checkbit_sync_filter #(
    .START_CODE (START_CODE),
    .PASS_CODE  (PASS_CODE),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clock     (clock),
    .resetb    (resetb),
    .clear     (clear),
    .checkbits (checkbits),
    .code      (qual_code),
    .start_ev  (start_ev),
    .pass_ev   (pass_ev)
  );

  assign start_hit    = start_ev && (qual_code == START_CODE);
  assign pass_hit     = pass_ev && (qual_code == PASS_CODE);
  assign cnt_p1       = {1'b0, cnt} + (CNT_W+1)'(1);
  assign cnt_sat      = cnt_p1[CNT_W] ? cnt : cnt_p1[CNT_W-1:0];
  assign timeout_hit  = (cnt_p1 == (CNT_W+1)'(TIMEOUT_CYCLES));
  assign round_nx     = round_idx + 4'd1;
  assign round_active = (state == RUN);

  // Round FSM with latency counter and sticky result registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      cnt        <= '0;
      round_idx  <= '0;
      lat_valid  <= 1'b0;
      lat_cycles <= '0;
      pass_all   <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= FAIL_NONE;
    end else if (clear) begin
      state      <= IDLE;
      cnt        <= '0;
      round_idx  <= '0;
      lat_valid  <= 1'b0;
      lat_cycles <= '0;
      pass_all   <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= FAIL_NONE;
    end else begin
      lat_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_hit) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          cnt <= cnt_sat;
          if (pass_hit) begin
            lat_cycles <= cnt_sat;
            lat_valid  <= 1'b1;
            round_idx  <= round_nx;
            if (round_nx == 4'(NUM_ROUNDS)) begin
              state    <= DONE;
              pass_all <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (start_hit) begin
            state     <= FAIL;
            fail      <= 1'b1;
            fail_code <= FAIL_RESTART;
          end else if (timeout_hit) begin
            state     <= FAIL;
            fail      <= 1'b1;
            fail_code <= FAIL_TIMEOUT;
          end
        end
        DONE, FAIL: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checkbit_round_monitor.sv
// Bench for checkbit_round_monitor: checkbit waveforms are
// built as (value, length) segments and scored by a round model.
module tb_checkbit_round_monitor;

  localparam int NR = 3;
  localparam int SC = 2;
  localparam int TO = 1000;
  localparam logic [15:0] ST = 16'h00A5;
  localparam logic [15:0] PS = 16'h765A;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_FAIL = 3;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] checkbits = '0;
  logic        round_active;
  logic [3:0]  round_idx;
  logic        lat_valid;
  logic [31:0] lat_cycles;
  logic        pass_all;
  logic        fail;
  logic [1:0]  fail_code;

  always #5 clock = ~clock;

  checkbit_round_monitor #(
    .START_CODE     (ST),
    .PASS_CODE      (PS),
    .NUM_ROUNDS     (NR),
    .CNT_W          (32),
    .TIMEOUT_CYCLES (32'(TO)),
    .STABLE_CYC     (SC)
  ) dut (
    .clock        (clock),
    .resetb       (resetb),
    .checkbits    (checkbits),
    .clear        (clear),
    .round_active (round_active),
    .round_idx    (round_idx),
    .lat_valid    (lat_valid),
    .lat_cycles   (lat_cycles),
    .pass_all     (pass_all),
    .fail         (fail),
    .fail_code    (fail_code)
  );

  int vectors = 0;
  int errs = 0;

  logic [15:0] seg_v[$];
  int          seg_n[$];
  int          exp_lat[$];
  int          got_lat[$];
  int          e_idx;
  int          e_pass;
  int          e_fail;
  int          e_code;

  always @(negedge clock) begin
    if (resetb && lat_valid) got_lat.push_back(int'(lat_cycles));
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "/active"}, 32'(round_active), 0);
    chk({tag, "/idx"}, 32'(round_idx), 0);
    chk({tag, "/lat_valid"}, 32'(lat_valid), 0);
    chk({tag, "/lat"}, lat_cycles, 0);
    chk({tag, "/pass_all"}, 32'(pass_all), 0);
    chk({tag, "/fail"}, 32'(fail), 0);
    chk({tag, "/code"}, 32'(fail_code), 0);
  endtask

  task automatic add(input logic [15:0] v, input int n);
    seg_v.push_back(v);
    seg_n.push_back(n);
  endtask

  task automatic hold(input logic [15:0] v, input int n);
    checkbits = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Round model over segments: a segment at least SC long that differs
  // from the current qualified code becomes a marker event at its start.
  task automatic model();
    int t = 0;
    int ts = 0;
    int st = M_IDLE;
    int idx = 0;
    int n;
    logic [15:0] q = '0;
    exp_lat.delete();
    e_pass = 0;
    e_fail = 0;
    e_code = 0;
    foreach (seg_v[i]) begin
      if (seg_n[i] >= SC && seg_v[i] != q) begin
        q = seg_v[i];
        n = t - ts;
        if (q == ST) begin
          if (st == M_IDLE) begin
            st = M_RUN;
            ts = t;
          end else if (st == M_RUN) begin
            st = M_FAIL;
            e_fail = 1;
            e_code = (n <= TO) ? 2 : 1;
          end
        end else if (q == PS && st == M_RUN) begin
          if (n <= TO) begin
            exp_lat.push_back(n);
            idx++;
            if (idx == NR) begin
              st = M_DONE;
              e_pass = 1;
            end else begin
              st = M_IDLE;
            end
          end else begin
            st = M_FAIL;
            e_fail = 1;
            e_code = 1;
          end
        end
      end
      t += seg_n[i];
    end
    if (st == M_RUN) begin
      e_fail = 1;
      e_code = 1;
      add(16'h0000, TO + 20);
    end else begin
      add(16'h0000, 12);
    end
    e_idx = idx;
  endtask

  task automatic run_scenario(input string tag, input bit by_reset);
    int m;
    if (by_reset) begin
      resetb = 1'b0;
      checkbits = '0;
      #1;
      zero_check({tag, "/rst"});
      @(posedge clock);
      #1;
      resetb = 1'b1;
    end else begin
      clear = 1'b1;
      checkbits = '0;
      @(posedge clock);
      #1;
      clear = 1'b0;
      zero_check({tag, "/clr"});
    end
    got_lat.delete();
    model();
    foreach (seg_v[i]) hold(seg_v[i], seg_n[i]);
    chk({tag, "/nlat"}, got_lat.size(), exp_lat.size());
    m = (got_lat.size() < exp_lat.size()) ? got_lat.size() : exp_lat.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s/lat%0d", tag, i), got_lat[i], exp_lat[i]);
    end
    chk({tag, "/lat_hold"}, lat_cycles,
        (exp_lat.size() > 0) ? exp_lat[exp_lat.size()-1] : 0);
    chk({tag, "/idx"}, 32'(round_idx), e_idx);
    chk({tag, "/pass_all"}, 32'(pass_all), e_pass);
    chk({tag, "/fail"}, 32'(fail), e_fail);
    chk({tag, "/code"}, 32'(fail_code), e_code);
    chk({tag, "/active"}, 32'(round_active), 0);
    seg_v.delete();
    seg_n.delete();
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] prev;
    int r;
    int n;
    int nseg;

    @(posedge clock);
    #1;

    for (int k = 0; k < 3; k++) begin
      add(ST, 500);
      add(PS, 10);
      add(16'h0000, 20);
    end
    run_scenario("three_rounds", 1'b1);

    add(ST, 10);
    add(PS, 10);
    run_scenario("clear_rerun", 1'b0);

    add(16'h0000, 5);
    add(ST, 20);
    add(PS, 1);
    add(16'h0000, 30);
    run_scenario("glitch_timeout", 1'b0);

    add(ST, 30);
    add(16'h1234, 30);
    add(ST, 30);
    run_scenario("restart", 1'b0);

    add(PS, 50);
    add(16'h0000, 5);
    add(ST, 200);
    add(PS, 10);
    run_scenario("pass_idle", 1'b0);

    hold(ST, 100);
    chk("midrun/active", 32'(round_active), 1);
    add(ST, 300);
    add(PS, 10);
    run_scenario("midrun_reset", 1'b1);

    for (int s = 0; s < 12; s++) begin
      prev = '0;
      nseg = $urandom_range(4, 10);
      for (int k = 0; k < nseg; k++) begin
        r = $urandom_range(0, 9);
        if (r < 3) v = ST;
        else if (r < 6) v = PS;
        else if (r < 8) v = 16'h0000;
        else v = 16'($urandom);
        if (v == prev) v = v ^ 16'h0101;
        r = $urandom_range(0, 9);
        if (r < 2) n = 1;
        else if (r < 4) n = $urandom_range(2, 4);
        else n = $urandom_range(20, 300);
        add(v, n);
        prev = v;
      end
      run_scenario($sformatf("rnd%0d", s), (s % 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
